// File: rtl/jpeg_quantizer_stream_if.sv
// Valid/ready coefficient stream: one signed sample per transfer plus a block-end flag.
// Latency: none, this is a bundle of wires; the master drives valid/data/last, the slave drives ready.
// Backpressure: a transfer happens only on cycles where valid && ready are both high.
// Ports: valid, ready, data (W-bit signed), last.
interface jpeg_quantizer_stream_if #(
    parameter int W = 11
) ();
    logic                valid;
    logic                ready;
    logic signed [W-1:0] data;
    logic                last;

    modport master (output valid, output data, output last, input ready);
    modport slave  (input valid, input data, input last, output ready);
endinterface

// File: rtl/jpeg_quantizer_stream.sv
// JPEG coefficient quantizer: out = round(in * recip / 2^FRAC), recip taken from a 64-entry table by raster index.
// Latency: 3 cycles from input transfer to out_valid (capture, multiply, round/limit), one coefficient per cycle.
// Backpressure: the whole pipeline advances only when !out_valid || out_ready; in_ready equals that advance.
// Ports: clk, rst (sync, active high), tbl_we/tbl_addr/tbl_data (table write), in_s (slave stream),
//        out_m (master stream), frame_err (sticky in_last position error).
// Build option: define JPEG_QUANT_SAT_EN to clamp results to the OUT_W signed range; otherwise results wrap.
module jpeg_quantizer_stream #(
    parameter int IN_W    = 11,
    parameter int OUT_W   = 11,
    parameter int RECIP_W = 13,
    parameter int FRAC    = 12
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       tbl_we,
    input  logic [5:0]                 tbl_addr,
    input  logic [RECIP_W-1:0]         tbl_data,
    jpeg_quantizer_stream_if.slave     in_s,
    jpeg_quantizer_stream_if.master    out_m,
    output logic                       frame_err
);
    localparam int PROD_W = IN_W + RECIP_W + 1;
    // One spare bit so adding the rounding constant can never overflow.
    localparam int SUM_W  = PROD_W + 1;

    localparam logic [RECIP_W-1:0]      ONE = RECIP_W'(64'd1 << FRAC);
    localparam logic signed [SUM_W-1:0] RND = SUM_W'(64'sd1 <<< (FRAC - 1));

    // Reciprocal table and block position
    logic [RECIP_W-1:0] tbl_q [64];
    logic [RECIP_W-1:0] tbl_d [64];
    logic [5:0]         idx_q, idx_d;
    logic               ferr_q, ferr_d;

    // Stage 1: captured coefficient and its table entry
    logic                      s1_vld_q, s1_vld_d;
    logic signed [IN_W-1:0]    s1_dat_q, s1_dat_d;
    logic [RECIP_W-1:0]        s1_ent_q, s1_ent_d;
    logic                      s1_last_q, s1_last_d;

    // Stage 2: full-precision product
    logic                      s2_vld_q, s2_vld_d;
    logic signed [PROD_W-1:0]  s2_prod_q, s2_prod_d;
    logic                      s2_last_q, s2_last_d;

    // Stage 3: rounded and limited result
    logic                      o_vld_q, o_vld_d;
    logic signed [OUT_W-1:0]   o_dat_q, o_dat_d;
    logic                      o_last_q, o_last_d;

    logic                      adv;
    logic                      acc;
    logic signed [PROD_W-1:0]  a_ext, b_ext, prod_c;
    logic signed [SUM_W-1:0]   sum_c, shr_c;
    logic signed [OUT_W-1:0]   res_c;

    always_comb begin
        // Multiply: signed coefficient times zero-extended unsigned entry.
        a_ext  = PROD_W'(s1_dat_q);
        b_ext  = $signed(PROD_W'(s1_ent_q));
        prod_c = a_ext * b_ext;

        // Arithmetic shift after adding one half rounds ties toward +infinity.
        sum_c  = SUM_W'(s2_prod_q) + RND;
        shr_c  = sum_c >>> FRAC;
`ifdef JPEG_QUANT_SAT_EN
        begin
            localparam logic signed [SUM_W-1:0] OMAX = SUM_W'((64'sd1 <<< (OUT_W - 1)) - 64'sd1);
            localparam logic signed [SUM_W-1:0] OMIN = -OMAX - SUM_W'(1);
            if (shr_c > OMAX) begin
                res_c = OUT_W'(OMAX);
            end else if (shr_c < OMIN) begin
                res_c = OUT_W'(OMIN);
            end else begin
                res_c = OUT_W'(shr_c);
            end
        end
`else
        res_c  = OUT_W'(shr_c);
`endif
    end

    always_comb begin
        adv       = !o_vld_q || out_m.ready;
        acc       = in_s.valid && adv;

        tbl_d     = tbl_q;
        idx_d     = idx_q;
        ferr_d    = ferr_q;
        s1_vld_d  = s1_vld_q;
        s1_dat_d  = s1_dat_q;
        s1_ent_d  = s1_ent_q;
        s1_last_d = s1_last_q;
        s2_vld_d  = s2_vld_q;
        s2_prod_d = s2_prod_q;
        s2_last_d = s2_last_q;
        o_vld_d   = o_vld_q;
        o_dat_d   = o_dat_q;
        o_last_d  = o_last_q;

        // The read below uses tbl_q, so a same-cycle write is seen only by later coefficients.
        if (tbl_we) begin
            tbl_d[tbl_addr] = tbl_data;
        end

        // Counter follows transfers only; a misplaced in_last is flagged but never resyncs it.
        if (acc) begin
            idx_d = idx_q + 6'd1;
            if (in_s.last != (idx_q == 6'd63)) begin
                ferr_d = 1'b1;
            end
        end

        if (adv) begin
            s1_vld_d  = in_s.valid;
            s1_dat_d  = in_s.data;
            s1_ent_d  = tbl_q[idx_q];
            s1_last_d = in_s.valid && (idx_q == 6'd63);
            s2_vld_d  = s1_vld_q;
            s2_prod_d = prod_c;
            s2_last_d = s1_last_q;
            o_vld_d   = s2_vld_q;
            o_dat_d   = s2_vld_q ? res_c : '0;
            o_last_d  = s2_vld_q && s2_last_q;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < 64; i++) begin
                tbl_q[i] <= ONE;
            end
            idx_q     <= '0;
            ferr_q    <= 1'b0;
            s1_vld_q  <= 1'b0;
            s1_dat_q  <= '0;
            s1_ent_q  <= '0;
            s1_last_q <= 1'b0;
            s2_vld_q  <= 1'b0;
            s2_prod_q <= '0;
            s2_last_q <= 1'b0;
            o_vld_q   <= 1'b0;
            o_dat_q   <= '0;
            o_last_q  <= 1'b0;
        end else begin
            tbl_q     <= tbl_d;
            idx_q     <= idx_d;
            ferr_q    <= ferr_d;
            s1_vld_q  <= s1_vld_d;
            s1_dat_q  <= s1_dat_d;
            s1_ent_q  <= s1_ent_d;
            s1_last_q <= s1_last_d;
            s2_vld_q  <= s2_vld_d;
            s2_prod_q <= s2_prod_d;
            s2_last_q <= s2_last_d;
            o_vld_q   <= o_vld_d;
            o_dat_q   <= o_dat_d;
            o_last_q  <= o_last_d;
        end
    end

    assign in_s.ready  = adv;
    assign out_m.valid = o_vld_q;
    assign out_m.data  = o_dat_q;
    assign out_m.last  = o_last_q;
    assign frame_err   = ferr_q;
endmodule

// File: tb/tb_jpeg_quantizer_stream.sv
module tb_jpeg_quantizer_stream;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        tbl_we = 1'b0;
    logic [5:0]  tbl_addr = '0;
    logic [12:0] tbl_data = '0;
    logic        frame_err;

    jpeg_quantizer_stream_if #(.W(11)) in_if ();
    jpeg_quantizer_stream_if #(.W(11)) out_if ();

    jpeg_quantizer_stream dut (
        .clk       (clk),
        .rst       (rst),
        .tbl_we    (tbl_we),
        .tbl_addr  (tbl_addr),
        .tbl_data  (tbl_data),
        .in_s      (in_if),
        .out_m     (out_if),
        .frame_err (frame_err)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Reference state: what the quantizer should hold, expressed as plain numbers.
    int tbl_m [64];
    int idx_m;
    bit ferr_m;

    typedef struct {
        int d;
        bit l;
        bit has_hard;
        int hard;
    } exp_t;
    exp_t exp_q [$];

    typedef struct {
        int coef;
        int recip;
        int exp_wrap;
        int exp_sat;
    } vec_t;
    vec_t vecs [12];

    task automatic chk(input string nm, input longint act, input longint req);
        checks++;
        if (act != req) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d", nm, act, req);
        end
    endtask

    // round(x*e / 4096) with ties toward +infinity, then fitted to 11-bit signed.
    function automatic int quant(input int x, input int e);
        longint p, s, q;
        p = longint'(x) * longint'(e);
        s = p + 2048;
        q = s / 4096;
        if ((s % 4096 != 0) && (s < 0)) q = q - 1;
`ifdef JPEG_QUANT_SAT_EN
        if (q > 1023) q = 1023;
        if (q < -1024) q = -1024;
`else
        q = ((q % 2048) + 2048) % 2048;
        if (q >= 1024) q = q - 2048;
`endif
        return int'(q);
    endfunction

    function automatic void model_reset();
        for (int i = 0; i < 64; i++) tbl_m[i] = 4096;
        idx_m  = 0;
        ferr_m = 1'b0;
        exp_q.delete();
    endfunction

    task automatic do_reset();
        @(posedge clk); #1;
        rst = 1'b1; in_if.valid = 1'b0; tbl_we = 1'b0; out_if.ready = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        model_reset();
    endtask

    task automatic write_entry(input int a, input int v);
        @(posedge clk); #1;
        tbl_we = 1'b1; tbl_addr = 6'(a); tbl_data = 13'(v);
        @(posedge clk); #1;
        tbl_we = 1'b0;
        tbl_m[a] = v;
    endtask

    // Single coefficient, then wait (bounded) for its result and measure latency.
    task automatic send_one(input int x, input int req, input string nm);
        int lat = 0;
        bit got = 0;
        @(posedge clk); #1;
        in_if.valid = 1'b1; in_if.data = 11'(x); in_if.last = 1'b0; out_if.ready = 1'b1;
        @(posedge clk); #1;
        in_if.valid = 1'b0;
        idx_m++;
        repeat (10) begin
            @(negedge clk);
            lat++;
            if (out_if.valid) begin
                got = 1;
                break;
            end
        end
        if (!got) begin
            chk({nm, "_timeout"}, 0, 1);
        end else begin
            chk({nm, "_latency"}, lat, 3);
            chk({nm, "_data"}, int'(out_if.data), req);
        end
    endtask

    function automatic int gen(input int mode, input int sent);
        int r;
        r = int'($urandom_range(2047)) - 1024;
        if (mode == 0) begin
            if (sent % 64 == 0) r = -1024;
            if (sent % 64 == 1) r = 0;
            if (sent % 64 == 2) r = 1023;
        end else if (mode == 1 && idx_m == 5) begin
            r = ((sent / 64) % 2 == 0) ? 100 : -100;
        end
        return r;
    endfunction

    function automatic int pick_recip();
        case ($urandom_range(5))
            0: return 0;
            1: return 4096;
            2: return 256;
            3: return 1365;
            4: return 8191;
            default: return int'($urandom_range(8191));
        endcase
    endfunction

    // Continuous input stream scored against the reference queue.
    // mode 0: random with extremes, 1: entry 5 probes (+/-100), 2: random table writes mid-stream.
    task automatic run_stream(input int n, input bit rnd_rdy, input int mode, input bit inj_err);
        int  sent = 0, cyc = 0, first_out = -1, last_out = -1;
        int  cur = 0;
        bit  have = 0, done = 0, inj_done = 0, ferr_pend = 0;
        exp_t e;
        while (!done) begin
            @(posedge clk); #1;
            if (!have && sent < n) begin
                cur  = gen(mode, sent);
                have = 1;
            end
            in_if.valid  = have;
            in_if.data   = 11'(cur);
            in_if.last   = (idx_m == 63) ^ (inj_err && !inj_done && idx_m == 10);
            out_if.ready = rnd_rdy ? 1'($urandom_range(1)) : 1'b1;
            if (mode == 2 && $urandom_range(9) == 0) begin
                tbl_we   = 1'b1;
                tbl_addr = 6'($urandom_range(63));
                tbl_data = 13'(pick_recip());
            end else begin
                tbl_we = 1'b0;
            end

            @(negedge clk);
            cyc++;
            if (ferr_pend) begin
                chk("frame_err_set", frame_err, 1);
                ferr_pend = 0;
            end
            if (out_if.valid && out_if.ready) begin
                if (exp_q.size() == 0) begin
                    chk("spurious_output", 1, 0);
                end else begin
                    e = exp_q.pop_front();
                    chk("stream_data", int'(out_if.data), e.d);
                    chk("stream_last", out_if.last, e.l);
                    if (e.has_hard) chk("probe_entry5", int'(out_if.data), e.hard);
                end
                if (first_out < 0) first_out = cyc;
                last_out = cyc;
            end
            if (in_if.valid && in_if.ready) begin
                e.d        = quant(cur, tbl_m[idx_m]);
                e.l        = (idx_m == 63);
                e.has_hard = (mode == 1 && idx_m == 5);
                e.hard     = (cur > 0) ? 6 : -6;
                exp_q.push_back(e);
                if (in_if.last != (idx_m == 63)) begin
                    chk("frame_err_before", frame_err, ferr_m);
                    ferr_m    = 1'b1;
                    ferr_pend = 1;
                    inj_done  = 1;
                end
                idx_m = (idx_m + 1) % 64;
                sent++;
                have = 0;
            end
            if (tbl_we) tbl_m[tbl_addr] = int'(tbl_data);
            if (sent == n && exp_q.size() == 0) done = 1;
            if (cyc > n * 4 + 50) begin
                chk("stream_timeout", 0, 1);
                done = 1;
            end
        end
        @(posedge clk); #1;
        in_if.valid = 1'b0; tbl_we = 1'b0; out_if.ready = 1'b1;
        @(negedge clk);
        chk("frame_err_end", frame_err, ferr_m);
        if (!rnd_rdy) chk("throughput_span", last_out - first_out, n - 1);
    endtask

    initial begin
        int nout;
        vecs[0]  = '{100,  256,  6,    6};
        vecs[1]  = '{-100, 256,  -6,   -6};
        vecs[2]  = '{0,    4096, 0,    0};
        vecs[3]  = '{1023, 4096, 1023, 1023};
        vecs[4]  = '{-1024,4096, -1024,-1024};
        vecs[5]  = '{500,  0,    0,    0};
        vecs[6]  = '{1023, 8191, -2,   1023};
        vecs[7]  = '{-1024,8191, 0,    -1024};
        vecs[8]  = '{1,    2048, 1,    1};
        vecs[9]  = '{-1,   2048, 0,    0};
        vecs[10] = '{7,    1365, 2,    2};
        vecs[11] = '{1000, 8191, -48,  1023};

        in_if.valid = 1'b0; in_if.data = '0; in_if.last = 1'b0; out_if.ready = 1'b1;
        model_reset();
        repeat (2) @(posedge clk);
        do_reset();

        @(negedge clk);
        chk("rst_out_valid", out_if.valid, 0);
        chk("rst_out_data", int'(out_if.data), 0);
        chk("rst_out_last", out_if.last, 0);
        chk("rst_frame_err", frame_err, 0);
        chk("rst_in_ready", in_if.ready, 1);

        // Vector i uses table index i, which is where the counter sits after reset.
        for (int i = 0; i < 12; i++) begin
            write_entry(i, vecs[i].recip);
`ifdef JPEG_QUANT_SAT_EN
            send_one(vecs[i].coef, vecs[i].exp_sat, $sformatf("vec%0d", i));
`else
            send_one(vecs[i].coef, vecs[i].exp_wrap, $sformatf("vec%0d", i));
`endif
        end

        do_reset();
        run_stream(64, 1'b0, 0, 1'b0);
        run_stream(192, 1'b1, 0, 1'b0);

        do_reset();
        write_entry(5, 256);
        run_stream(128, 1'b0, 1, 1'b0);
        run_stream(128, 1'b1, 2, 1'b0);

        do_reset();
        run_stream(128, 1'b0, 0, 1'b1);

        // Reset with two coefficients in flight.
        do_reset();
        write_entry(0, 256);
        @(posedge clk); #1;
        in_if.valid = 1'b1; in_if.data = 11'(100); in_if.last = 1'b0; out_if.ready = 1'b1;
        @(posedge clk); #1;
        in_if.data = 11'(200);
        @(posedge clk); #1;
        in_if.valid = 1'b0; rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        model_reset();
        @(negedge clk);
        chk("midrst_out_valid", out_if.valid, 0);
        chk("midrst_in_ready", in_if.ready, 1);
        nout = 0;
        repeat (5) begin
            @(negedge clk);
            if (out_if.valid) nout++;
        end
        chk("midrst_no_output", nout, 0);
        run_stream(64, 1'b0, 0, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/jpeg_quantizer_stream.md
JPEG_QUANTIZER_STREAM -- requirements
Module: jpeg_quantizer_stream

Interface
REQ-001 Parameter IN_W, default 11, signed DCT coefficient input width.
REQ-002 Parameter OUT_W, default 11, signed quantized output width.
REQ-003 Parameter RECIP_W, default 13, unsigned reciprocal table entry width.
REQ-004 Parameter FRAC, default 12, fixed-point fraction bits of reciprocal (entry = 2^FRAC / Q).
REQ-005 clk  input  1  sole clock, all logic on rising edge.
REQ-006 rst  input  1  synchronous, active-high reset.
REQ-007 tbl_we  input  1  table write strobe.
REQ-008 tbl_addr  input  6  table entry index, raster order 0..63.
REQ-009 tbl_data  input  RECIP_W  reciprocal value written.
REQ-010 in_valid  input  1  input coefficient valid.
REQ-011 in_ready  output  1  block accepts input this cycle.
REQ-012 in_data  input  IN_W  signed coefficient.
REQ-013 in_last  input  1  marks last coefficient of an 8x8 block.
REQ-014 out_valid  output  1  output coefficient valid.
REQ-015 out_ready  input  1  downstream accepts output.
REQ-016 out_data  output  OUT_W  signed quantized coefficient.
REQ-017 out_last  output  1  last coefficient of block, aligned with out_data.
REQ-018 frame_err  output  1  sticky: in_last position mismatch.

Function
REQ-019 Input transfer SHALL occur on cycles with in_valid && in_ready; output transfer on out_valid && out_ready.
REQ-020 Pipeline SHALL be 3 stages (register input+entry, multiply, round/saturate); latency 3 cycles from input transfer to out_valid with out_ready held high.
REQ-021 Global advance = !out_valid || out_ready; in_ready SHALL equal advance; all stages hold when not advancing; no data lost or duplicated.
REQ-022 Sustained throughput SHALL be one coefficient per cycle when out_ready is high.
REQ-023 Internal 6-bit index counter SHALL select table entry per accepted coefficient, increment per transfer, wrap 63->0.
REQ-024 out_last SHALL be high for the coefficient accepted at index 63; counter wraps regardless of in_last.
REQ-025 in_last at index != 63, or in_last low at index 63, SHALL set frame_err until reset; counter not resynchronized.
REQ-026 Product = in_data (signed) * entry (unsigned, zero-extended), full precision IN_W+RECIP_W+1 bits.
REQ-027 Result = (product + 2^(FRAC-1)) >>> FRAC (arithmetic shift; rounds half toward +infinity).
REQ-028 Table write SHALL take effect for coefficients accepted on cycles after the write cycle; same-cycle write and read of one entry returns old value.
REQ-029 Entry value 0 SHALL yield output 0.

Reset
REQ-030 On rst: out_valid=0, out_data=0, out_last=0, frame_err=0, index counter=0, all stage valids cleared.
REQ-031 On rst all 64 table entries SHALL be set to 2^FRAC (Q=1, identity).
REQ-032 Reset mid-block SHALL discard in-flight data; in_ready high the cycle after rst deasserts.

Configuration
REQ-033 Macro JPEG_QUANT_SAT_EN defined: result outside OUT_W signed range SHALL clamp to max/min (1023/-1024 at defaults).
REQ-034 Macro JPEG_QUANT_SAT_EN undefined: result SHALL be truncated to low OUT_W bits (two's-complement wrap).

Verification
REQ-035 After reset, no writes, feed 64 values incl. -1024, 0, 1023 -> identical outputs, out_last only on 64th, frame_err=0.
REQ-036 Write entry 5 = 256 (Q=16); feed 100 at index 5 -> 6; next block -100 at index 5 -> -6.
REQ-037 With JPEG_QUANT_SAT_EN, entry 0 = 8191, input 1023 -> 1023; input -1024 -> -1024; without macro input 1023 -> low 11 bits of 2046 (-2).
REQ-038 out_ready toggled random 50% over 3 blocks, in_valid continuous -> output sequence equals golden model, no drops/duplicates, 1 result/cycle when out_ready held high.
REQ-039 in_last asserted at index 10 -> frame_err=1 from next cycle, stays high; counter continues, out_last still at index 63.
REQ-040 rst asserted with 2 coefficients in flight -> out_valid=0 next cycle, counter=0, table restored to 4096.
